safe_code_engine: RTL and testbench

Parametrised code-guessing game core: holds a secret code of `DIGITS` symbols, scores each submitted guess with a sequential exact/misplaced evaluator, and tracks a BCD attempt count with win/lose detection. It sits between the digit-entry/key-debounce logic and the hex marquee in the DE1_SoC game top. It generalises the fixed 4-digit, 2-bit-symbol, 99-try safe game to any code length, symbol width and try limit. It also adds a free-running LFSR code source, a deterministic test-load path and a registered result handshake.

---
 rtl/safe_code_engine_if.sv | 39 +++
 rtl/safe_code_engine.sv | 166 ++++++++++++++++
 tb/tb_safe_code_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/safe_code_engine_if.sv
// Game-side bus of the safe code engine: guess/start entry from the key logic,
// scores and game status back to the display logic.
interface safe_code_engine_if #(
  parameter int DIGITS = 4,
  parameter int SYM_W  = 2
);
  localparam int CODE_W = DIGITS * SYM_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  logic              start;
  logic              ld_code;
  logic [CODE_W-1:0] ld_val;
  logic [CODE_W-1:0] guess;
  logic              submit;
  logic [CODE_W-1:0] code;
  logic              playing;
  logic              busy;
  logic              result_valid;
  logic [CNT_W-1:0]  n_correct;
  logic [CNT_W-1:0]  n_misplaced;
  logic [7:0]        tries_bcd;
  logic              won;
  logic              lost;
  logic [2:0]        dbg_state;

  // Handshake: submit is taken only while playing && !busy (no ready line);
  // result_valid is a one-cycle pulse with no back-pressure, so the
  // consumer must capture the scores on that cycle or read them while held.
  modport master (
    output start, ld_code, ld_val, guess, submit,
    input  code, playing, busy, result_valid, n_correct, n_misplaced,
           tries_bcd, won, lost, dbg_state
  );
  modport slave (
    input  start, ld_code, ld_val, guess, submit,
    output code, playing, busy, result_valid, n_correct, n_misplaced,
           tries_bcd, won, lost, dbg_state
  );
endinterface

// File: rtl/safe_code_engine.sv
// Code-guessing game core: secret code from LFSR or test load, sequential
// exact/misplaced scoring, BCD try counter with win/lose detection.
module safe_code_engine #(
  parameter int               DIGITS    = 4,
  parameter int               SYM_W     = 2,
  parameter int               MAX_TRIES = 99,
  parameter int               LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED     = 16'h0001
) (
  input  logic                clk,
  input  logic                reset,
  safe_code_engine_if.slave   bus
);
  localparam int CODE_W = DIGITS * SYM_W;
  localparam int NSYM   = 1 << SYM_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int MAXN   = (DIGITS > NSYM) ? DIGITS : NSYM;
  localparam int IDX_W  = $clog2(MAXN);
  localparam logic [7:0] MAX_BCD = {4'(MAX_TRIES / 10), 4'(MAX_TRIES % 10)};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    EXACT = 3'd2,
    MISP  = 3'd3,
    WON   = 3'd4,
    LOST  = 3'd5
  } state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] guess_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  exact_acc;
  logic [CNT_W-1:0]  total_acc;
  logic [CNT_W-1:0]  n_correct_q;
  logic [CNT_W-1:0]  n_misplaced_q;
  logic [7:0]        tries_q;
  logic              won_q;
  logic              lost_q;
  logic              rv_q;

  logic [LFSR_W-1:0] lfsr_next;
  logic [SYM_W-1:0]  g_dig;
  logic [SYM_W-1:0]  c_dig;
  logic [SYM_W-1:0]  sym;
  logic [CNT_W-1:0]  cnt_code;
  logic [CNT_W-1:0]  cnt_guess;
  logic [CNT_W-1:0]  min_cnt;
  logic [CNT_W-1:0]  total_nxt;
  logic [7:0]        tries_nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Galois right-shift: a non-zero state never maps to zero.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign sym       = idx[SYM_W-1:0];

  always_comb begin
    g_dig     = '0;
    c_dig     = '0;
    cnt_code  = '0;
    cnt_guess = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        g_dig = guess_q[i*SYM_W +: SYM_W];
        c_dig = code_q[i*SYM_W +: SYM_W];
      end
      if (code_q[i*SYM_W +: SYM_W] == sym)  cnt_code  = cnt_code + CNT_W'(1);
      if (guess_q[i*SYM_W +: SYM_W] == sym) cnt_guess = cnt_guess + CNT_W'(1);
    end
    min_cnt   = (cnt_code < cnt_guess) ? cnt_code : cnt_guess;
    total_nxt = total_acc + min_cnt;
    tries_nxt = bcd_inc(tries_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= SEED;
      code_q        <= '0;
      guess_q       <= '0;
      idx           <= '0;
      exact_acc     <= '0;
      total_acc     <= '0;
      n_correct_q   <= '0;
      n_misplaced_q <= '0;
      tries_q       <= '0;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
      rv_q          <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      rv_q <= 1'b0;
      if (bus.start && (state != EXACT) && (state != MISP)) begin
        code_q        <= bus.ld_code ? bus.ld_val : lfsr[CODE_W-1:0];
        tries_q       <= '0;
        won_q         <= 1'b0;
        lost_q        <= 1'b0;
        n_correct_q   <= '0;
        n_misplaced_q <= '0;
        state         <= PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (bus.submit) begin
              guess_q   <= bus.guess;
              exact_acc <= '0;
              total_acc <= '0;
              idx       <= '0;
              state     <= EXACT;
            end
          end
          EXACT: begin
            if (g_dig == c_dig) exact_acc <= exact_acc + CNT_W'(1);
            if (idx == IDX_W'(DIGITS - 1)) begin
              idx   <= '0;
              state <= MISP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          MISP: begin
            total_acc <= total_nxt;
            if (idx == IDX_W'(NSYM - 1)) begin
              // Every symbol counted: publish the score and judge the game.
              n_correct_q   <= exact_acc;
              n_misplaced_q <= total_nxt - exact_acc;
              tries_q       <= tries_nxt;
              rv_q          <= 1'b1;
              idx           <= '0;
              if (exact_acc == CNT_W'(DIGITS)) begin
                won_q <= 1'b1;
                state <= WON;
              end else if (tries_nxt == MAX_BCD) begin
                lost_q <= 1'b1;
                state  <= LOST;
              end else begin
                state <= PLAY;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.code         = code_q;
  assign bus.playing      = (state == PLAY) || (state == EXACT) || (state == MISP);
  assign bus.busy         = (state == EXACT) || (state == MISP);
  assign bus.result_valid = rv_q;
  assign bus.n_correct    = n_correct_q;
  assign bus.n_misplaced  = n_misplaced_q;
  assign bus.tries_bcd    = tries_q;
  assign bus.won          = won_q;
  assign bus.lost         = lost_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_safe_code_engine.sv
// Bench for safe_code_engine: default instance plus a MAX_TRIES=3 instance,
// table vectors, random games against a counting model, and hazard sequences.
module tb_safe_code_engine;
  logic       clk = 1'b0;
  logic       reset;
  logic       start, ld_code, submit, sel;
  logic [7:0] ld_val, guess;

  int errors = 0;
  int checks = 0;
  int m_tries;

  always #5 clk = ~clk;

  safe_code_engine_if #(.DIGITS(4), .SYM_W(2)) b0 ();
  safe_code_engine_if #(.DIGITS(4), .SYM_W(2)) b3 ();

  safe_code_engine u_dut (.clk(clk), .reset(reset), .bus(b0.slave));
  safe_code_engine #(.MAX_TRIES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  assign b0.start   = start & ~sel;
  assign b0.submit  = submit & ~sel;
  assign b0.ld_code = ld_code;
  assign b0.ld_val  = ld_val;
  assign b0.guess   = guess;
  assign b3.start   = start & sel;
  assign b3.submit  = submit & sel;
  assign b3.ld_code = ld_code;
  assign b3.ld_val  = ld_val;
  assign b3.guess   = guess;

  logic [7:0] m_code, m_tries_bcd;
  logic [2:0] m_nc, m_nm, m_state;
  logic       m_rv, m_won, m_lost, m_playing, m_busy;
  assign m_code      = sel ? b3.code         : b0.code;
  assign m_tries_bcd = sel ? b3.tries_bcd    : b0.tries_bcd;
  assign m_nc        = sel ? b3.n_correct    : b0.n_correct;
  assign m_nm        = sel ? b3.n_misplaced  : b0.n_misplaced;
  assign m_state     = sel ? b3.dbg_state    : b0.dbg_state;
  assign m_rv        = sel ? b3.result_valid : b0.result_valid;
  assign m_won       = sel ? b3.won          : b0.won;
  assign m_lost      = sel ? b3.lost         : b0.lost;
  assign m_playing   = sel ? b3.playing      : b0.playing;
  assign m_busy      = sel ? b3.busy         : b0.busy;

  typedef struct {
    bit         fresh;
    logic [7:0] code;
    logic [7:0] guess;
    int         ec;
    int         em;
  } vec_t;
  vec_t tbl[6];

  // Scoring from the game rules: positional matches, and per-symbol minimum
  // of occurrences for the total.
  function automatic void score(input logic [7:0] c, input logic [7:0] g,
                                output int ex, output int mi);
    int cc[4];
    int gc[4];
    int tot;
    ex = 0; tot = 0;
    for (int s = 0; s < 4; s++) begin cc[s] = 0; gc[s] = 0; end
    for (int i = 0; i < 4; i++) begin
      cc[c[i*2 +: 2]]++;
      gc[g[i*2 +: 2]]++;
      if (c[i*2 +: 2] == g[i*2 +: 2]) ex++;
    end
    for (int s = 0; s < 4; s++) tot += (cc[s] < gc[s]) ? cc[s] : gc[s];
    mi = tot - ex;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic new_game(input logic ld, input logic [7:0] val);
    start = 1'b1; ld_code = ld; ld_val = val;
    tick();
    start = 1'b0; ld_code = 1'b0;
    m_tries = 0;
    check("start_playing", m_playing, 1);
    check("start_tries", m_tries_bcd, 8'h00);
    check("start_won", m_won, 0);
    check("start_lost", m_lost, 0);
    check("start_scores", {m_nc, m_nm}, 0);
    if (ld) check("start_code", m_code, val);
  endtask

  task automatic play_guess(input logic [7:0] g, input int ec, input int em,
                            input logic ew, input logic el);
    int k;
    logic seen;
    guess = g; submit = 1'b1;
    tick();
    submit = 1'b0;
    guess = 8'($urandom);
    check("busy_rise", m_busy, 1);
    k = 0; seen = m_rv;
    while (!seen && k < 20) begin
      tick();
      k++;
      seen = m_rv;
    end
    m_tries++;
    check("result_seen", seen, 1);
    if (seen) begin
      check("latency", k, 8);
      check("n_correct", m_nc, ec);
      check("n_misplaced", m_nm, em);
      check("tries_bcd", m_tries_bcd, to_bcd(m_tries));
      check("won", m_won, ew);
      check("lost", m_lost, el);
      check("playing", m_playing, !(ew || el));
      check("busy_fall", m_busy, 0);
      tick();
      check("rv_one_cycle", m_rv, 0);
    end
  endtask

  task automatic count_rv(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (m_rv) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c1, c2, rc, gu;
    int ex, mi, n;

    tbl[0] = '{1'b1, 8'h1B, 8'h1B, 4, 0};
    tbl[1] = '{1'b1, 8'h1B, 8'hE4, 0, 4};
    tbl[2] = '{1'b0, 8'h1B, 8'h1E, 2, 2};
    tbl[3] = '{1'b1, 8'h00, 8'h03, 3, 0};
    tbl[4] = '{1'b1, 8'h05, 8'h50, 0, 4};
    tbl[5] = '{1'b0, 8'h05, 8'h55, 2, 0};

    sel = 1'b0; start = 1'b0; ld_code = 1'b0; submit = 1'b0;
    ld_val = '0; guess = '0; reset = 1'b1; m_tries = 0;
    repeat (3) tick();
    check("rst_state", m_state, 0);
    check("rst_code", m_code, 0);
    check("rst_tries", m_tries_bcd, 0);
    check("rst_flags", {m_rv, m_won, m_lost, m_playing, m_busy}, 0);
    check("rst_scores", {m_nc, m_nm}, 0);
    reset = 1'b0;

    tick(); tick();
    new_game(1'b0, 8'h00); c1 = m_code;
    repeat (5) tick();
    new_game(1'b0, 8'h00); c2 = m_code;
    check("lfsr_codes_differ", (c1 != c2), 1);

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].fresh) new_game(1'b1, tbl[v].code);
      play_guess(tbl[v].guess, tbl[v].ec, tbl[v].em, (tbl[v].ec == 4), 1'b0);
    end

    for (int gm = 0; gm < 6; gm++) begin
      rc = 8'($urandom);
      new_game(1'b1, rc);
      for (int t = 0; t < 8; t++) begin
        gu = (t == 7) ? rc : 8'($urandom_range(0, 255));
        score(rc, gu, ex, mi);
        play_guess(gu, ex, mi, (ex == 4), 1'b0);
        if (ex == 4) break;
      end
    end

    new_game(1'b1, 8'h1B);
    guess = 8'hE4; submit = 1'b1;
    tick();
    submit = 1'b0;
    tick(); tick();
    check("busy_before_extra_submit", m_busy, 1);
    submit = 1'b1;
    tick();
    submit = 1'b0;
    count_rv(20, n);
    check("busy_submit_pulses", n, 1);
    check("busy_submit_tries", m_tries_bcd, 8'h01);

    start = 1'b1; submit = 1'b1; ld_code = 1'b1; ld_val = 8'h2D;
    tick();
    start = 1'b0; submit = 1'b0; ld_code = 1'b0;
    check("ss_code", m_code, 8'h2D);
    check("ss_busy", m_busy, 0);
    check("ss_playing", m_playing, 1);
    check("ss_tries", m_tries_bcd, 8'h00);
    count_rv(12, n);
    check("ss_no_result", n, 0);

    new_game(1'b1, 8'h1B);
    guess = 8'h1B; submit = 1'b1;
    tick();
    submit = 1'b0;
    repeat (5) tick();
    check("misp2_state", m_state, 3'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_state", m_state, 0);
    check("midrst_code", m_code, 0);
    check("midrst_flags", {m_rv, m_won, m_lost, m_playing, m_busy}, 0);
    check("midrst_out", {m_nc, m_nm, m_tries_bcd}, 0);
    count_rv(10, n);
    check("midrst_no_result", n, 0);

    new_game(1'b1, 8'h00);
    for (int t = 1; t <= 99; t++) begin
      play_guess(8'hFF, 0, 0, 1'b0, (t == 99));
      if (t == 10) begin
        check("bcd_ten", m_tries_bcd, 8'h10);
        check("bcd_ten_lost", m_lost, 0);
      end
    end
    check("bcd_99", m_tries_bcd, 8'h99);
    check("bcd_99_lost", m_lost, 1);

    sel = 1'b1;
    new_game(1'b1, 8'h00);
    play_guess(8'hFF, 0, 0, 1'b0, 1'b0);
    play_guess(8'h55, 0, 0, 1'b0, 1'b0);
    play_guess(8'hAA, 0, 0, 1'b0, 1'b1);
    check("loss_tries", m_tries_bcd, 8'h03);
    guess = 8'h00; submit = 1'b1;
    tick();
    submit = 1'b0;
    count_rv(15, n);
    check("loss_no_result", n, 0);
    check("loss_held", {m_lost, m_tries_bcd}, {1'b1, 8'h03});
    new_game(1'b1, 8'h00);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
